// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and divider helper for the UART receiver
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int          OVERSAMPLE  = 16;
    localparam logic [3:0]  SAMPLE_LO   = 4'd7;
    localparam logic [3:0]  SAMPLE_MID  = 4'd8;
    localparam logic [3:0]  SAMPLE_HI   = 4'd9;
    localparam logic [3:0]  SAMPLE_LAST = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int uart_div(input int clk_hz, input int baud);
        longint num;
        longint den;
        den = longint'(baud) * longint'(OVERSAMPLE);
        num = longint'(clk_hz) + (den >> 1);
        return int'(num / den);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous first-word-fallthrough FIFO with occupancy count
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampling UART receiver feeding a receive FIFO
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_i,
    output logic [DATA_BITS-1:0]          m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          overflow_o
);

    localparam int               DIV       = uart_div(CLK_FREQ, BAUD);
    localparam int               DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_next;
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic [DIV_W-1:0]     div_cnt;
    logic [3:0]           samp_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 s7_q;
    logic                 s8_q;
    logic                 par_bad_q;
    logic                 stop_bad_q;

    logic tick;
    logic bit_end;
    logic at_mid;
    logic at_vote;
    logic vote;
    logic rx_fall;
    logic start_det;
    logic push_ev;
    logic frame_err_ev;
    logic parity_err_ev;
    logic fifo_full;
    logic fifo_empty;
    logic pop;

    assign tick    = (state != ST_IDLE) && (div_cnt == DIV_LAST);
    assign bit_end = tick && (samp_cnt == SAMPLE_LAST);
    assign at_mid  = tick && (samp_cnt == SAMPLE_MID);
    assign at_vote = tick && (samp_cnt == SAMPLE_HI);
    assign vote    = (s7_q & s8_q) | (s7_q & rx_sync) | (s8_q & rx_sync);
    assign rx_fall = rx_prev && !rx_sync;

    // Two-flop synchroniser plus one history flop for edge detection; idle line is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receive state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and frame-completion events; the last stop bit is judged mid-bit.
    always_comb begin
        state_next    = state;
        start_det     = 1'b0;
        push_ev       = 1'b0;
        frame_err_ev  = 1'b0;
        parity_err_ev = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_fall) begin
                    state_next = ST_START;
                    start_det  = 1'b1;
                end
            end
            ST_START: begin
                if (at_mid && rx_sync) begin
                    state_next = ST_IDLE;
                end else if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && bit_cnt == LAST_DATA) begin
                    state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (at_vote && bit_cnt == LAST_STOP) begin
                    if (stop_bad_q || !vote) begin
                        frame_err_ev = 1'b1;
                        state_next   = ST_WAIT_IDLE;
                    end else if (par_bad_q) begin
                        parity_err_ev = 1'b1;
                        state_next    = ST_IDLE;
                    end else begin
                        push_ev    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_sync) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Tick divider, sample/bit counters, majority samples, shift register and error latches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt    <= '0;
            samp_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            s7_q       <= 1'b1;
            s8_q       <= 1'b1;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
        end else begin
            if (state == ST_IDLE || div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (state == ST_IDLE) begin
                samp_cnt <= '0;
            end else if (tick) begin
                samp_cnt <= samp_cnt + 1'b1;
            end

            if (state != state_next) begin
                bit_cnt <= '0;
            end else if (bit_end) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (tick && samp_cnt == SAMPLE_LO) begin
                s7_q <= rx_sync;
            end
            if (at_mid) begin
                s8_q <= rx_sync;
            end

            if (start_det) begin
                par_bad_q  <= 1'b0;
                stop_bad_q <= 1'b0;
            end else if (at_vote) begin
                if (state == ST_DATA) begin
                    shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                end
                if (state == ST_PARITY) begin
                    par_bad_q <= (^shift_q) ^ vote ^ (PARITY == PAR_ODD);
                end
                if (state == ST_STOP) begin
                    stop_bad_q <= stop_bad_q | ~vote;
                end
            end
        end
    end

    assign m_valid_o = !fifo_empty;
    assign pop       = m_valid_o && m_ready_i;

    // Registered one-cycle status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            frame_err_o  <= frame_err_ev;
            parity_err_o <= parity_err_ev;
            overflow_o   <= push_ev && fifo_full && !pop;
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_ev),
        .push_data (shift_q),
        .pop       (pop),
        .pop_data  (m_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fill_o)
    );

endmodule
